pipe_stage_reg: RTL

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg_pkg.sv | 29 ++
 rtl/pipe_entry.sv | 45 ++++
 rtl/pipe_stage_reg.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg_pkg
// Shared CPU definitions used by the pipeline stage register:
//   - default payload / control widths
//   - bit positions of the side-effect control field
//   - occupancy state encoding of the stage (doubles as the entry count)
// ---------------------------------------------------------------------------
package pipe_stage_reg_pkg;

    // Payload: PC+4, ALU result, store data and destination register.
    localparam int CPU_DATA_W = 101;
    // Control: MemToReg[1:0], MemWrite, MemRead, RegWrite, is_lb.
    localparam int CPU_CTRL_W = 6;

    localparam int CTRL_MEM_TO_REG_HI = 5;
    localparam int CTRL_MEM_TO_REG_LO = 4;
    localparam int CTRL_MEM_WRITE     = 3;
    localparam int CTRL_MEM_READ      = 2;
    localparam int CTRL_REG_WRITE     = 1;
    localparam int CTRL_IS_LB         = 0;

    // Encoded so that the state value equals the number of valid entries.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL1 = 2'd1,
        ST_FULL2 = 2'd2
    } stage_state_t;

endpackage

// File: rtl/pipe_entry.sv
// ---------------------------------------------------------------------------
// pipe_entry
// One storage slot of the stage: valid bit, control field and payload.
//   clk, reset   : clock, synchronous active-high reset (clears everything)
//   load         : capture d_ctrl/d_data and set valid
//   clear        : drop the entry; valid and ctrl go to 0, data is kept
//   d_ctrl/d_data: value to capture on load
//   valid/ctrl/data : registered contents
// clear wins over load. ctrl is zero whenever valid is zero, so an empty
// slot can never carry a live write enable.
// ---------------------------------------------------------------------------
module pipe_entry
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int CTRL_W = CPU_CTRL_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [DATA_W-1:0] d_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            ctrl  <= '0;
            data  <= '0;
        end else if (clear) begin
            // Payload is deliberately left untouched.
            valid <= 1'b0;
            ctrl  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            ctrl  <= d_ctrl;
            data  <= d_data;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
// Pipeline stage register with valid/ready handshakes and flush.
//   clk, reset          : clock, synchronous active-high reset
//   in_valid/in_ready   : upstream handshake, in_data/in_ctrl payload
//   out_valid/out_ready : downstream handshake, out_data/out_ctrl payload
//   flush               : kill everything held in or entering the stage
//   occupancy           : number of valid entries (0..2), equals FSM state
//
// Handshake: a transfer happens on a rising edge where valid & ready are
// both high; valid never depends on ready, and a producer holding valid
// keeps its payload stable until the transfer.
//
// SKID=1: main + skid entry. in_ready = !skid_valid (only reset also gates
// it), so there is no combinational path from out_ready to in_ready.
// SKID=0: main entry only, in_ready = !out_valid | out_ready.
// ---------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int CTRL_W = CPU_CTRL_W,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              flush,
    output logic [1:0]        occupancy
);

    stage_state_t state;
    stage_state_t state_next;

    logic              push;
    logic              pop;
    logic              main_load;
    logic              main_clear;
    logic              main_from_skid;
    logic              skid_load;
    logic              skid_clear;
    logic              main_valid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign out_ctrl  = main_valid ? main_ctrl : '0;
    assign occupancy = state;

    generate
        if (SKID != 0) begin : g_ready_skid
            assign in_ready = !reset && !skid_valid;
        end else begin : g_ready_single
            assign in_ready = !reset && (!main_valid || out_ready);
        end
    endgenerate

    assign push = in_valid && in_ready;
    assign pop  = main_valid && out_ready;

    // State register: the state value is the registered occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next state and entry controls. With SKID=0 the FULL1 push-without-pop
    // case cannot occur because in_ready is low then, so FULL2 is unreachable.
    always_comb begin
        state_next     = state;
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        if (flush) begin
            state_next = ST_EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (push) begin
                        main_load  = 1'b1;
                        state_next = ST_FULL1;
                    end
                end
                ST_FULL1: begin
                    if (push && pop) begin
                        main_load = 1'b1;
                    end else if (push) begin
                        skid_load  = 1'b1;
                        state_next = ST_FULL2;
                    end else if (pop) begin
                        main_clear = 1'b1;
                        state_next = ST_EMPTY;
                    end
                end
                ST_FULL2: begin
                    // Older skid entry moves up behind the departing head.
                    if (pop) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                        state_next     = ST_FULL1;
                    end
                end
                default: begin
                    state_next = ST_EMPTY;
                end
            endcase
        end
    end

    pipe_entry #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_main (
        .clk    (clk),
        .reset  (reset),
        .load   (main_load),
        .clear  (main_clear),
        .d_ctrl (main_from_skid ? skid_ctrl : in_ctrl),
        .d_data (main_from_skid ? skid_data : in_data),
        .valid  (main_valid),
        .ctrl   (main_ctrl),
        .data   (main_data)
    );

    generate
        if (SKID != 0) begin : g_skid
            pipe_entry #(
                .DATA_W (DATA_W),
                .CTRL_W (CTRL_W)
            ) u_skid (
                .clk    (clk),
                .reset  (reset),
                .load   (skid_load),
                .clear  (skid_clear),
                .d_ctrl (in_ctrl),
                .d_data (in_data),
                .valid  (skid_valid),
                .ctrl   (skid_ctrl),
                .data   (skid_data)
            );
        end else begin : g_no_skid
            logic unused_skid;
            assign skid_valid  = 1'b0;
            assign skid_ctrl   = '0;
            assign skid_data   = '0;
            assign unused_skid = skid_load ^ skid_clear;
        end
    endgenerate

endmodule
